// File: rtl/lsu.sv
// Load/store unit: word-organised data RAM plus memory-mapped LED/HEX/LCD outputs and switch inputs.
// Optional macro LSU_SW_DEBOUNCE_EN enables per-bit switch debouncing (DEBOUNCE_CYCLES stable cycles).
module lsu #(
  parameter int DMEM_AW         = 13,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex07,
  input  logic [31:0] i_io_sw
);

  localparam logic [31:0] LEDR_ADDR = 32'h1000_0000;
  localparam logic [31:0] LEDG_ADDR = 32'h1000_1000;
  localparam logic [31:0] HEX_ADDR  = 32'h1000_2000;
  localparam logic [31:0] LCD_ADDR  = 32'h1000_3000;
  localparam logic [31:0] SW_ADDR   = 32'h1001_0000;
  localparam int          RAM_WORDS = 2 ** (DMEM_AW - 2);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

  logic [31:0]        mem_r [RAM_WORDS];
  logic [31:0]        ledr_r, ledg_r, lcd_r;
  logic [6:0]         hex_r;
  logic [31:0]        sw_sync1_r, sw_sync2_r, sw_rep_s;
  logic [31:0]        word_addr_s, rd_word_s, ld_data_s, wdata_s;
  logic [3:0]         be_s;
  logic               misaligned_s, wr_en_s;
  logic               ram_hit_s, ledr_hit_s, ledg_hit_s, hex_hit_s, lcd_hit_s, sw_hit_s;
  logic [DMEM_AW-3:0] ram_idx_s;
  logic [7:0]         byte_s;
  logic [15:0]        half_s;

  assign word_addr_s = {i_lsu_addr[31:2], 2'b00};
  assign ram_idx_s   = i_lsu_addr[DMEM_AW-1:2];
  assign ram_hit_s   = (i_lsu_addr[31:DMEM_AW] == {(32-DMEM_AW){1'b0}});
  assign ledr_hit_s  = (word_addr_s == LEDR_ADDR);
  assign ledg_hit_s  = (word_addr_s == LEDG_ADDR);
  assign hex_hit_s   = (word_addr_s == HEX_ADDR);
  assign lcd_hit_s   = (word_addr_s == LCD_ADDR);
  assign sw_hit_s    = (word_addr_s == SW_ADDR);
  assign wr_en_s     = i_lsu_wren & ~misaligned_s & ~i_reset;

  // Alignment check, lane enables and lane-replicated store data
  always_comb begin
    misaligned_s = 1'b0;
    be_s         = 4'b1111;
    wdata_s      = i_st_data;
    case (i_lsu_size)
      2'b00: begin
        be_s    = 4'b0001 << i_lsu_addr[1:0];
        wdata_s = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        misaligned_s = i_lsu_addr[0];
        be_s         = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{i_st_data[15:0]}};
      end
      default: begin
        misaligned_s = (i_lsu_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Source word select; reads see pre-store contents
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (ram_hit_s) begin
      rd_word_s = mem_r[ram_idx_s];
    end else if (ledr_hit_s) begin
      rd_word_s = ledr_r;
    end else if (ledg_hit_s) begin
      rd_word_s = ledg_r;
    end else if (hex_hit_s) begin
      rd_word_s = {25'd0, hex_r};
    end else if (lcd_hit_s) begin
      rd_word_s = lcd_r;
    end else if (sw_hit_s) begin
      rd_word_s = i_reset ? 32'h0000_0000 : sw_rep_s;
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Lane extraction and sign/zero extension
  always_comb begin
    byte_s    = 8'h00;
    half_s    = i_lsu_addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    ld_data_s = rd_word_s;
    case (i_lsu_addr[1:0])
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    case (i_lsu_size)
      2'b00:   ld_data_s = {{24{byte_s[7] & ~i_lsu_unsigned}}, byte_s};
      2'b01:   ld_data_s = {{16{half_s[15] & ~i_lsu_unsigned}}, half_s};
      default: ld_data_s = rd_word_s;
    endcase
    if (misaligned_s) begin
      ld_data_s = 32'h0000_0000;
    end else begin
      ld_data_s = ld_data_s;
    end
  end

  assign o_ld_data    = ld_data_s;
  assign o_misaligned = misaligned_s;

  // Data RAM byte-lane writes (contents are never reset)
  always_ff @(posedge i_clk) begin
    if (wr_en_s && ram_hit_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_r[ram_idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
        end
      end
    end
  end

  // Output registers; HEX07 only accepts lane 0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_r <= 32'h0000_0000;
      ledg_r <= 32'h0000_0000;
      lcd_r  <= 32'h0000_0000;
      hex_r  <= 7'h00;
    end else if (wr_en_s) begin
      if (ledr_hit_s) ledr_r <= merge_lanes(ledr_r, wdata_s, be_s);
      if (ledg_hit_s) ledg_r <= merge_lanes(ledg_r, wdata_s, be_s);
      if (lcd_hit_s)  lcd_r  <= merge_lanes(lcd_r, wdata_s, be_s);
      if (hex_hit_s && be_s[0]) hex_r <= wdata_s[6:0];
    end
  end

  assign o_io_ledr  = ledr_r;
  assign o_io_ledg  = ledg_r;
  assign o_io_lcd   = lcd_r;
  assign o_io_hex07 = hex_r;

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_sync1_r <= 32'h0000_0000;
      sw_sync2_r <= 32'h0000_0000;
    end else begin
      sw_sync1_r <= i_io_sw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

`ifdef LSU_SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt_r [32];
  logic [31:0]   sw_db_r;

  // Per-bit debounce: adopt new value after DEBOUNCE_CYCLES consecutive differing cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_db_r <= 32'h0000_0000;
      for (int i = 0; i < 32; i++) db_cnt_r[i] <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (sw_sync2_r[i] != sw_db_r[i]) begin
          if (db_cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            sw_db_r[i]  <= sw_sync2_r[i];
            db_cnt_r[i] <= {CW{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
          end
        end else begin
          db_cnt_r[i] <= {CW{1'b0}};
        end
      end
    end
  end

  assign sw_rep_s = sw_db_r;
`else
  assign sw_rep_s = sw_sync2_r;
`endif

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-level memory-map model.
module tb_lsu;

  localparam logic [31:0] LEDR = 32'h1000_0000;
  localparam logic [31:0] LEDG = 32'h1000_1000;
  localparam logic [31:0] HEX  = 32'h1000_2000;
  localparam logic [31:0] LCD  = 32'h1000_3000;
  localparam logic [31:0] SW   = 32'h1001_0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_lsu_wren, i_lsu_unsigned;
  logic [31:0] i_lsu_addr, i_st_data, i_io_sw;
  logic [1:0]  i_lsu_size;
  logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
  logic        o_misaligned;
  logic [6:0]  o_io_hex07;

  lsu dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .i_lsu_wren(i_lsu_wren), .i_lsu_size(i_lsu_size), .i_lsu_unsigned(i_lsu_unsigned),
    .o_ld_data(o_ld_data), .o_misaligned(o_misaligned), .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg), .o_io_lcd(o_io_lcd), .o_io_hex07(o_io_hex07), .i_io_sw(i_io_sw)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: RAM bytes 0..63, output registers, switch samples (older first)
  logic [7:0]  ram_m [64];
  logic [31:0] ledr_m, ledg_m, lcd_m;
  logic [6:0]  hex_m;
  logic [31:0] sw_hist [2];
  logic [31:0] sw_cur;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] base, input bit rst);
    if (base < 64) return {ram_m[base+3], ram_m[base+2], ram_m[base+1], ram_m[base]};
    if (base == LEDR) return ledr_m;
    if (base == LEDG) return ledg_m;
    if (base == LCD)  return lcd_m;
    if (base == HEX)  return {25'd0, hex_m};
    if (base == SW)   return rst ? 32'd0 : sw_hist[0];
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size,
                                           input bit uns, input bit rst);
    int nb;
    logic [31:0] w, v, mask;
    nb = nbytes(size);
    if (is_mis(addr, size)) return 32'd0;
    w = word_of(addr & 32'hFFFF_FFFC, rst);
    if (nb == 4) return w;
    v    = w >> (8 * (addr % 4));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic void model_edge(input logic [31:0] addr, input logic [31:0] data,
                                     input bit wren, input logic [1:0] size, input bit rst);
    logic [31:0] base;
    logic [7:0]  b;
    int lane;
    if (rst) begin
      ledr_m = 32'd0; ledg_m = 32'd0; lcd_m = 32'd0; hex_m = 7'd0;
      sw_hist[0] = 32'd0; sw_hist[1] = 32'd0;
      return;
    end
    if (wren && !is_mis(addr, size)) begin
      base = addr & 32'hFFFF_FFFC;
      for (int k = 0; k < nbytes(size); k++) begin
        lane = int'(addr % 4) + k;
        b    = 8'((data >> (8 * k)) & 32'hFF);
        if (base < 64) ram_m[base+lane] = b;
        else if (base == LEDR) ledr_m[8*lane +: 8] = b;
        else if (base == LEDG) ledg_m[8*lane +: 8] = b;
        else if (base == LCD)  lcd_m[8*lane +: 8] = b;
        else if (base == HEX && lane == 0) hex_m = b[6:0];
      end
    end
    sw_hist[0] = sw_hist[1];
    sw_hist[1] = sw_cur;
  endfunction

  // One bus cycle: drive, compare combinational outputs, clock, compare registers
  task automatic do_cycle(input logic [31:0] addr, input logic [31:0] data, input bit wren,
                          input logic [1:0] size, input bit uns, input bit rst, input bit chk);
    i_lsu_addr = addr; i_st_data = data; i_lsu_wren = wren; i_lsu_size = size;
    i_lsu_unsigned = uns; i_reset = rst; i_io_sw = sw_cur;
`ifdef LSU_SW_DEBOUNCE_EN
    if ((addr & 32'hFFFF_FFFC) == SW) chk = 1'b0;
`endif
    #3;
    if (chk) check_val("ld_data", o_ld_data, exp_load(addr, size, uns, rst));
    check_val("misaligned", {31'd0, o_misaligned}, {31'd0, is_mis(addr, size)});
    @(posedge i_clk);
    model_edge(addr, data, wren, size, rst);
    #1;
    check_val("ledr", o_io_ledr, ledr_m);
    check_val("ledg", o_io_ledg, ledg_m);
    check_val("lcd", o_io_lcd, lcd_m);
    check_val("hex", {25'd0, o_io_hex07}, {25'd0, hex_m});
  endtask

  // Directed load with a fixed expected value
  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] exp);
    i_lsu_addr = addr; i_lsu_wren = 1'b0; i_lsu_size = size; i_lsu_unsigned = uns;
    i_reset = 1'b0; i_io_sw = sw_cur;
    #3;
    check_val(tag, o_ld_data, exp);
    @(posedge i_clk);
    model_edge(addr, 32'd0, 1'b0, size, 1'b0);
    #1;
  endtask

  logic [31:0] ra;
  logic [31:0] unm [4];

  initial begin
    unm[0] = 32'h0000_2000; unm[1] = 32'h1000_0004; unm[2] = 32'h1001_0004; unm[3] = 32'h2000_0000;
    sw_cur = 32'd0;
    i_reset = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = SW; i_st_data = 32'd0;
    i_lsu_size = 2'd2; i_lsu_unsigned = 1'b0; i_io_sw = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    ledr_m = 32'd0; ledg_m = 32'd0; lcd_m = 32'd0; hex_m = 7'd0;
    sw_hist[0] = 32'd0; sw_hist[1] = 32'd0;
    for (int i = 0; i < 64; i++) ram_m[i] = 8'd0;
    check_val("rst_ledr", o_io_ledr, 32'd0);
    check_val("rst_ledg", o_io_ledg, 32'd0);
    check_val("rst_lcd", o_io_lcd, 32'd0);
    check_val("rst_hex", {25'd0, o_io_hex07}, 32'd0);
    check_val("rst_sw_read", o_ld_data, 32'd0);

    for (int i = 0; i < 16; i++) do_cycle(32'(4 * i), $urandom, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);

    // Word store then signed/unsigned byte loads
    do_cycle(32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    load_chk("byte_signed", 32'h13, 2'd0, 1'b0, 32'hFFFF_FFDE);
    load_chk("byte_unsigned", 32'h13, 2'd0, 1'b1, 32'h0000_00DE);
    // Same-cycle store and load return the old word
    i_lsu_addr = 32'h10; i_st_data = 32'h55; i_lsu_wren = 1'b1; i_lsu_size = 2'd2;
    #3; check_val("rd_before_wr", o_ld_data, 32'hDEADBEEF);
    @(posedge i_clk); model_edge(32'h10, 32'h55, 1'b1, 2'd2, 1'b0); #1;
    load_chk("wr_committed", 32'h10, 2'd2, 1'b0, 32'h55);
    // Half store into a prior word
    do_cycle(32'h20, 32'hAABBCCDD, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    do_cycle(32'h22, 32'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    load_chk("half_merge", 32'h20, 2'd2, 1'b0, 32'h1234CCDD);
    // Misaligned word store is dropped
    do_cycle(32'h04, 32'h11223344, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    i_lsu_addr = 32'h06; i_st_data = 32'hCAFEF00D; i_lsu_wren = 1'b1; i_lsu_size = 2'd2;
    #3;
    check_val("mis_flag", {31'd0, o_misaligned}, 32'd1);
    check_val("mis_load_zero", o_ld_data, 32'd0);
    @(posedge i_clk); model_edge(32'h06, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0); #1;
    load_chk("mis_no_write", 32'h04, 2'd2, 1'b0, 32'h11223344);
    // HEX07 keeps only lane 0, 7 bits
    do_cycle(HEX, 32'h7F, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    do_cycle(HEX + 1, 32'hFF, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check_val("hex_value", {25'd0, o_io_hex07}, 32'h7F);
    load_chk("hex_load", HEX, 2'd2, 1'b0, 32'h7F);
    // Store during reset is discarded
    do_cycle(LEDR, 32'hFFFF, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    check_val("ledr_written", o_io_ledr, 32'hFFFF);
    do_cycle(LEDR, 32'h1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
    check_val("ledr_reset", o_io_ledr, 32'd0);
    // Switch path
    for (int i = 0; i < 3; i++) do_cycle(SW, 32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
`ifdef LSU_SW_DEBOUNCE_EN
    sw_cur = 32'h5;
    for (int i = 0; i < 3; i++) load_chk("sw_glitch", SW, 2'd2, 1'b0, 32'h0);
    sw_cur = 32'h0;
    for (int i = 0; i < 8; i++) load_chk("sw_glitch", SW, 2'd2, 1'b0, 32'h0);
`else
    sw_cur = 32'h5;
    load_chk("sw_cyc0", SW, 2'd2, 1'b0, 32'h0);
    load_chk("sw_cyc1", SW, 2'd2, 1'b0, 32'h0);
    load_chk("sw_cyc2", SW, 2'd2, 1'b0, 32'h5);
`endif

    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ra = 32'($urandom_range(0, 63));
        5:             ra = LEDR + 32'($urandom_range(0, 3));
        6:             ra = LEDG + 32'($urandom_range(0, 3));
        7:             ra = HEX + 32'($urandom_range(0, 3));
        8:             ra = ($urandom_range(0, 1) == 0 ? LCD : SW) + 32'($urandom_range(0, 3));
        default:       ra = unm[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 7) == 0) sw_cur = $urandom;
      do_cycle(ra, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DMEM_AW, default 13, byte-address width of data RAM (2^DMEM_AW bytes, word-organised).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, stable-cycle count for switch debounce (used only under REQ-030).
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_lsu_addr  in  32  byte address (core ALU result).
REQ-006 i_st_data  in  32  store data, right-aligned.
REQ-007 i_lsu_wren  in  1  store request this cycle.
REQ-008 i_lsu_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 i_lsu_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-010 o_ld_data  out  32  load data, aligned and extended.
REQ-011 o_misaligned  out  1  access violates natural alignment.
REQ-012 o_io_ledr / o_io_ledg / o_io_lcd  out  32 each  output registers; o_io_hex07  out  7  output register.
REQ-013 i_io_sw  in  32  asynchronous switch inputs.

Function
REQ-014 Map: 0x0000_0000 to 2^DMEM_AW-1 RAM; 0x1000_0000 LEDR; 0x1000_1000 LEDG; 0x1000_2000 HEX07; 0x1000_3000 LCD; 0x1001_0000 SW (read-only); full 32-bit address compare per IO word, addr[1:0] selects lanes.
REQ-015 Unmapped address: loads return 0, stores ignored, no error flag.
REQ-016 o_misaligned = 1 combinationally when half and addr[0]=1, or word and addr[1:0]!=00.
REQ-017 Misaligned store: no state changes; misaligned load: o_ld_data = 0.
REQ-018 Loads combinational, zero-cycle latency: o_ld_data reflects current RAM/register contents in the same cycle as i_lsu_addr.
REQ-019 Stores commit on the rising edge ending the cycle with i_lsu_wren=1; only addressed byte lanes change (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all).
REQ-020 Store data for byte/half taken from i_st_data[7:0]/[15:0], replicated to the selected lane(s).
REQ-021 Load extraction: byte lane addr[1:0], half lane pair addr[1]; bit 7/15 extended per i_lsu_unsigned; word passes unchanged.
REQ-022 Same-cycle load and store to one address: o_ld_data returns pre-store value.
REQ-023 HEX07 is 7 bits at lane 0; upper 25 bits read as 0; stores to lanes 1-3 of HEX07 ignored.
REQ-024 Stores to SW address ignored; SW load returns synchronised (or debounced) switch value.
REQ-025 i_io_sw passes through a 2-flop synchroniser; SW read value lags input by 2 cycles without debounce.

Reset
REQ-026 While i_reset=1 at a rising edge: LEDR, LEDG, LCD, HEX07 registers clear to 0, synchroniser and debounce state clear to 0.
REQ-027 A store presented in a cycle with i_reset=1 is discarded; RAM contents are not reset and not modified.
REQ-028 First store accepted is the one in the first cycle with i_reset=0.
REQ-029 Outputs o_ld_data and o_misaligned stay combinational through reset (SW reads 0 during reset).

Configuration
REQ-030 Macro LSU_SW_DEBOUNCE_EN defined: each switch bit has a counter; the reported bit updates to the synchronised value only after it has differed from the reported bit for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the counter. Undefined: reported value = synchroniser output, no counters synthesised.

Verification
REQ-031 Word store 0xDEADBEEF to 0x0000_0010, then byte load 0x0000_0013 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-032 Half store 0x1234 to 0x0000_0022 over prior word 0xAABBCCDD at 0x20 -> word load 0x0000_0020 = 0x1234CCDD.
REQ-033 Word store to 0x0000_0006 -> o_misaligned=1, RAM word at 0x04 unchanged, load returns 0.
REQ-034 Word store 0x0000007F to 0x1000_2000, then byte store 0xFF to 0x1000_2001 -> o_io_hex07 = 0x7F, load of 0x1000_2000 = 0x0000007F.
REQ-035 i_io_sw 0x0 -> 0x5 at cycle 0 -> SW load = 0x5 from cycle 2 (no macro); with LSU_SW_DEBOUNCE_EN and a 3-cycle glitch, SW load stays 0x0.
REQ-036 LEDR written 0xFFFF, i_reset=1 one cycle together with store 0x1 to LEDR -> o_io_ledr = 0 after that edge.
